// File: rtl/mpram_pkg.sv
// ----------------------------------------------------------------------------
// mpram_pkg
// Shared definitions for the parameterized multi-port RAM:
//   - mpram_state_t : init-sweep FSM state encoding (ST_INIT / ST_READY)
//   - PRIO_A        : which write port wins a same-address write collision
//                     (1 = port a wins, port b is dropped)
// ----------------------------------------------------------------------------
package mpram_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } mpram_state_t;

    localparam logic PRIO_A = 1'b1;

endpackage

// File: rtl/mpram_init_fsm.sv
// ----------------------------------------------------------------------------
// mpram_init_fsm
// Zero-fill sweep controller. After reset it walks the array two words per
// cycle (even word on the port-a write path, odd word on the port-b path),
// then parks in READY until the next reset.
//
// Ports:
//   clk             in   rising-edge clock
//   rst             in   asynchronous active-high reset (restarts the sweep)
//   busy            out  high while the sweep runs
//   sweep_en        out  sweep writes are active this cycle
//   sweep_addr_even out  even address being cleared this cycle ({cnt,0})
//   sweep_addr_odd  out  odd address being cleared this cycle  ({cnt,1})
// ----------------------------------------------------------------------------
module mpram_init_fsm
    import mpram_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              sweep_en,
    output logic [ADDR_W-1:0] sweep_addr_even,
    output logic [ADDR_W-1:0] sweep_addr_odd
);

    localparam int CNT_W = ADDR_W - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH / 2 - 1);

    mpram_state_t     state;
    mpram_state_t     next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // The last pair is cleared in the cycle where cnt == CNT_LAST; the FSM
    // leaves INIT on that edge, so cnt never wraps.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        busy       = 1'b0;
        sweep_en   = 1'b0;
        case (state)
            ST_INIT: begin
                busy     = 1'b1;
                sweep_en = 1'b1;
                if (cnt == CNT_LAST) begin
                    next_state = ST_READY;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            ST_READY: begin
                next_state = ST_READY;
            end
            default: begin
                next_state = ST_INIT;
                next_cnt   = '0;
            end
        endcase
    end

    assign sweep_addr_even = {cnt, 1'b0};
    assign sweep_addr_odd  = {cnt, 1'b1};

endmodule

// File: rtl/parameterized_multi_port_ram.sv
// ----------------------------------------------------------------------------
// parameterized_multi_port_ram
// Synchronous RAM with two read/write ports (a, b) and NUM_RD read-only
// ports. All reads are registered (1-cycle latency). After reset the array
// is swept to zero while busy is high; user writes are ignored then.
// Same-address writes on a and b: port a wins and collision pulses for one
// cycle.
//
// Build option:
//   MPRAM_BYPASS_EN defined   -> write-first: reads of an address written in
//                                the same cycle return the new data
//   MPRAM_BYPASS_EN undefined -> read-first: such reads return old contents
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   data_a, data_b   write data, ports a/b
//   addr_a, addr_b   read/write addresses, ports a/b
//   we_a, we_b       write enables
//   addr_rd          packed read addresses, port i = [i*ADDR_W +: ADDR_W]
//   q_a, q_b         registered read data, ports a/b
//   q_rd             packed registered read data, port i = [i*DATA_W +: DATA_W]
//   busy             init sweep in progress
//   collision        one-cycle pulse after a same-address double write
// ----------------------------------------------------------------------------
module parameterized_multi_port_ram
    import mpram_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        data_a,
    input  logic [DATA_W-1:0]        data_b,
    input  logic [ADDR_W-1:0]        addr_a,
    input  logic [ADDR_W-1:0]        addr_b,
    input  logic                     we_a,
    input  logic                     we_b,
    input  logic [NUM_RD*ADDR_W-1:0] addr_rd,
    output logic [DATA_W-1:0]        q_a,
    output logic [DATA_W-1:0]        q_b,
    output logic [NUM_RD*DATA_W-1:0] q_rd,
    output logic                     busy,
    output logic                     collision
);

    localparam int NUM_PORTS = NUM_RD + 2;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              sweep_en;
    logic [ADDR_W-1:0] sweep_addr_even;
    logic [ADDR_W-1:0] sweep_addr_odd;
    logic              ready;
    logic              collide_now;
    logic              commit_a;
    logic              commit_b;
    logic              wr_en_a;
    logic              wr_en_b;
    logic [ADDR_W-1:0] wr_addr_a;
    logic [ADDR_W-1:0] wr_addr_b;
    logic [DATA_W-1:0] wr_data_a;
    logic [DATA_W-1:0] wr_data_b;
    logic [ADDR_W-1:0] rd_addr [NUM_PORTS];
    logic [DATA_W-1:0] rd_val  [NUM_PORTS];

    mpram_init_fsm #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_init_fsm (
        .clk             (clk),
        .rst             (rst),
        .busy            (busy),
        .sweep_en        (sweep_en),
        .sweep_addr_even (sweep_addr_even),
        .sweep_addr_odd  (sweep_addr_odd)
    );

    assign ready       = ~busy;
    assign collide_now = ready & we_a & we_b & (addr_a == addr_b);
    // On a collision exactly one of the two writes survives, chosen by PRIO_A.
    assign commit_a    = ready & we_a & ~(collide_now & ~PRIO_A);
    assign commit_b    = ready & we_b & ~(collide_now & PRIO_A);

    // The sweep owns both write paths while busy; user commits are already
    // gated off by ready, so the mux only needs to pick the source.
    assign wr_en_a   = sweep_en | commit_a;
    assign wr_en_b   = sweep_en | commit_b;
    assign wr_addr_a = sweep_en ? sweep_addr_even : addr_a;
    assign wr_addr_b = sweep_en ? sweep_addr_odd  : addr_b;
    assign wr_data_a = sweep_en ? '0 : data_a;
    assign wr_data_b = sweep_en ? '0 : data_b;

    always_ff @(posedge clk) begin
        if (wr_en_a) begin
            mem[wr_addr_a] <= wr_data_a;
        end
        if (wr_en_b) begin
            mem[wr_addr_b] <= wr_data_b;
        end
    end

    // Slot 0 = port a, slot 1 = port b, slots 2.. = read-only ports.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            rd_addr[i] = '0;
        end
        rd_addr[0] = addr_a;
        rd_addr[1] = addr_b;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_addr[i+2] = addr_rd[i*ADDR_W +: ADDR_W];
        end
    end

    // Port a forwarding is applied last so its data wins if both could match.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            rd_val[i] = mem[rd_addr[i]];
`ifdef MPRAM_BYPASS_EN
            if (commit_b && (rd_addr[i] == addr_b)) begin
                rd_val[i] = data_b;
            end
            if (commit_a && (rd_addr[i] == addr_a)) begin
                rd_val[i] = data_a;
            end
`endif
        end
    end

    // Outputs are held at zero for the whole sweep, including its final edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_a       <= '0;
            q_b       <= '0;
            q_rd      <= '0;
            collision <= 1'b0;
        end else if (!ready) begin
            q_a       <= '0;
            q_b       <= '0;
            q_rd      <= '0;
            collision <= 1'b0;
        end else begin
            q_a       <= rd_val[0];
            q_b       <= rd_val[1];
            for (int i = 0; i < NUM_RD; i++) begin
                q_rd[i*DATA_W +: DATA_W] <= rd_val[i+2];
            end
            collision <= collide_now;
        end
    end

endmodule
